// File: rtl/clk_div_sel_if.sv
// rtl/clk_div_sel_if.sv - control and output bundle of the selectable clock divider
interface clk_div_sel_if #(
    parameter int SEL_W = 2
);
    logic             en;
    logic [SEL_W-1:0] sel;
    logic             clk_out;
    logic             tick;
    logic [SEL_W-1:0] sel_ack;

    modport master (
        output en,
        output sel,
        input  clk_out,
        input  tick,
        input  sel_ack
    );

    modport slave (
        input  en,
        input  sel,
        output clk_out,
        output tick,
        output sel_ack
    );
endinterface

// File: rtl/clk_div_sel.sv
// rtl/clk_div_sel.sv - multi-rate square-wave and tick generator with glitch-free rate switching
module clk_div_sel #(
    parameter int DIV_BASE = 5000000,
    parameter int N_SEL    = 4,
    parameter int SEL_W    = 2,
    parameter int CNT_W    = 23
) (
    input  logic               clk,
    input  logic               rst_n,
    clk_div_sel_if.slave       bus
);
    localparam logic [CNT_W-1:0] BASE    = CNT_W'(DIV_BASE);
    localparam logic [SEL_W-1:0] SEL_MAX = SEL_W'(N_SEL - 1);

    logic [SEL_W-1:0] sel_s1;
    logic [SEL_W-1:0] sel_s2;
    logic [SEL_W-1:0] sel_eff;
    logic [SEL_W-1:0] sel_ack_r;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] half_m1;
    logic             clk_out_r;
    logic             tick_r;

    // Switch input is asynchronous; the synchroniser runs even while held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_s1 <= '0;
            sel_s2 <= '0;
        end else begin
            sel_s1 <= bus.sel;
            sel_s2 <= sel_s1;
        end
    end

    assign sel_eff = (sel_s2 > SEL_MAX) ? SEL_MAX : sel_s2;
    assign half_m1 = (BASE >> sel_ack_r) - CNT_W'(1);

    // sel_ack only moves on a rising transition, so every half period is whole.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            clk_out_r <= 1'b0;
            tick_r    <= 1'b0;
            sel_ack_r <= '0;
        end else if (bus.en) begin
            if (cnt == half_m1) begin
                cnt       <= '0;
                clk_out_r <= ~clk_out_r;
                if (!clk_out_r) begin
                    sel_ack_r <= sel_eff;
                    tick_r    <= 1'b1;
                end else begin
                    tick_r    <= 1'b0;
                end
            end else begin
                cnt    <= cnt + CNT_W'(1);
                tick_r <= 1'b0;
            end
        end else begin
            tick_r <= 1'b0;
        end
    end

    assign bus.clk_out = clk_out_r;
    assign bus.tick    = tick_r;
    assign bus.sel_ack = sel_ack_r;
endmodule

// File: doc/clk_div_sel.md
Name: clk_div_sel

Overview:
- Parametrised multi-rate clock-enable and square-wave generator for the Spartan-3E LCD kit designs.
- Divides the 50 MHz board clock into N_SEL selectable rates. Rate k has half-period DIV_BASE>>k cycles, so the defaults give 5/10/20/40 Hz.
- Rate changes are applied only at a period boundary, so the output never shows a runt pulse.
- Also provides a one-cycle tick, a run/hold enable, and a 2-FF synchroniser on the switch-driven select.

Parameters:
- DIV_BASE, 5000000: half-period in clk cycles of the slowest rate (sel=0).
- N_SEL, 4: number of selectable rates. DIV_BASE>>(N_SEL-1) must be >= 1.
- SEL_W, 2: width of sel; must satisfy 2^SEL_W >= N_SEL.
- CNT_W, 23: counter width; must satisfy 2^CNT_W > DIV_BASE.

Ports:
- clk, input, 1: system clock (50 MHz).
- rst_n, input, 1: asynchronous active-low reset.
- en, input, 1: run when 1; hold all state when 0. Synchronous to clk.
- sel, input, SEL_W: rate select from slide switches. Asynchronous; synchronised internally.
- clk_out, output, 1: divided square wave, 50% duty.
- tick, output, 1: one-cycle pulse coincident with the first cycle of each clk_out high phase.
- sel_ack, output, SEL_W: rate currently in effect.

Behaviour:
- Reset (asynchronous, active-low; released synchronously by the board):
  - cnt=0, clk_out=0, tick=0, sel_ack=0.
  - Synchroniser flops sel_s1=0, sel_s2=0.
- Select synchroniser: sel -> sel_s1 -> sel_s2, always clocked regardless of en. Latency is 2 clk.
- Select clamping: if sel_s2 >= N_SEL, the value treated as selected is N_SEL-1.
- Half-period: HALF = DIV_BASE >> sel_ack.
- Each clk edge with en=1:
  - If cnt == HALF-1: cnt <= 0 and clk_out <= ~clk_out.
    - If clk_out was 0 (rising transition): sel_ack <= clamped sel_s2 and tick <= 1.
    - Otherwise tick <= 0.
  - Else: cnt <= cnt+1, tick <= 0.
- en=0: cnt, clk_out and sel_ack hold; tick <= 0. On re-enable, counting resumes from the held cnt with no phase loss.
- Rate change takes effect only at a rising edge of clk_out. The high half of that period and every later half use the new HALF.
  - A change made during a high half is not applied until the following rising edge.
  - A select that toggles and returns before that rising edge has no effect.
- First rising edge after reset (en=1, sel=0): clk_out=1 after HALF(0) clk edges. tick is high during exactly that first high cycle.
- Period at rate k is 2*(DIV_BASE>>k) cycles, with exact 50% duty.
- HALF=1 (fastest legal rate) gives clk_out toggling every cycle. tick then pulses every 2 cycles.
- Reset asserted mid-count: all state clears immediately, asynchronously. Output low, sel_ack=0.

Test Plan (DIV_BASE=8, N_SEL=4, SEL_W=2, CNT_W=4):
1. Release rst_n with en=1, sel=0 -> clk_out rises on the 8th clk edge, period 16 cycles, high 8/low 8, tick high exactly 1 cycle per period, sel_ack=0.
2. Running at sel=0, set sel=2 during a low half -> at the next rising edge sel_ack=2; high half = 2 cycles, then period 4 cycles with tick every 4 cycles. No clk_out phase shorter than 2 cycles or longer than 8.
3. Set sel=1 during a high half at sel=3 (HALF=1) -> the current high half stays 1 cycle; switch occurs at the next rising edge, then period 8 cycles.
4. Drop en for 5 cycles mid low-half -> clk_out, cnt and sel_ack frozen and tick=0 during the hold. After en returns, the remaining low-half length equals the pre-hold remainder.
5. Pulse sel 0->3->0 within 1 cycle while low at sel=0 -> sel_ack stays 0, period stays 16.
6. Assert rst_n low at a random point while clk_out=1 -> clk_out=0, tick=0, sel_ack=0 immediately without waiting for a clk edge. After release, scenario 1 timing repeats.
